bcd_seg7_scan: RTL and testbench
================================

// Module: bcd_seg7_scan
// PURPOSE
//  Downstream display stage for the BCD counters (e.g. mod-60 seconds/minutes):
//  captures a packed multi-digit BCD word via valid/ready, then time-multiplexes
//  it onto one shared 7-segment bus with per-digit enables. The shadow register
//  changes only at frame boundaries, so a count rollover never tears a frame.
// PARAMETERS
//  DIGITS         4      number of BCD digits scanned (2..8)
//  SCAN_DIV       50000  clk cycles per digit slot (>=2)
//  SEG_ACT_LOW    1      1: seg/dp active-low; 0: active-high
//  DIG_ACT_LOW    1      1: dig_sel active-low; 0: active-high
//  DP_POS         2      digit index carrying the blinking dp (macro only)
// PORTS
//  clk         in   1          system clock, rising edge
//  rst         in   1          asynchronous reset, active-high
//  bcd_in      in   4*DIGITS   packed BCD; [3:0] = digit 0 (least significant)
//  bcd_vld     in   1          bcd_in valid
//  bcd_rdy     out  1          block can accept bcd_in
//  blank_lz    in   1          1: blank leading zeros
//  seg         out  7          segments {g,f,e,d,c,b,a}
//  dp          out  1          decimal point
//  dig_sel     out  DIGITS     one-hot digit enable
//  frame_done  out  1          1-cycle pulse at the end of every full scan
// BEHAVIOUR
//  Reset: seg/dp/dig_sel at inactive level, frame_done=0, bcd_rdy=1;
//   prescaler, digit index, shadow, pending register, frame counter = 0.
//  Prescaler counts 0..SCAN_DIV-1; at terminal count the index advances
//   0->1->..->DIGITS-1->0. Boundary = terminal count while index=DIGITS-1;
//   frame_done pulses on the cycle after the boundary.
//  Outputs registered: seg/dp/dig_sel show slot k one cycle after index=k;
//   exactly one dig_sel bit active at all times outside reset.
//  Handshake: transfer when bcd_vld & bcd_rdy. Outside boundary: word goes to
//   pending, bcd_rdy=0 next cycle. At boundary, pending (if any) moves to
//   shadow and bcd_rdy returns to 1 next cycle. Transfer on the boundary cycle
//   itself goes directly to shadow (bypasses pending), bcd_rdy stays 1.
//   Worst-case accept latency = one frame (DIGITS*SCAN_DIV cycles).
//  Decode (active-high gfedcba): 0=0111111 1=0000110 2=1011011 3=1001111
//   4=1100110 5=1101101 6=1111101 7=0000111 8=1111111 9=1101111;
//   nibble A..F -> dash 1000000. SEG_ACT_LOW inverts.
//  Leading-zero blanking (blank_lz=1): digits from DIGITS-1 downward that are
//   0, up to the first nonzero, drive all segments inactive; digit 0 never
//   blanked; dig_sel still scans. blank_lz sampled per slot, no latching.
//  Reset mid-frame: everything returns to reset values immediately; pending
//   data discarded; scan restarts at digit 0 after rst deasserts.
// CONFIGURATION
//  SEG7_DP_BLINK_EN defined: 6-bit frame counter increments on each
//   frame_done; dp active on slot DP_POS when frame_cnt[5]=1, else inactive.
//  Not defined: no frame counter; dp permanently inactive.
// TESTING  (DIGITS=4, SCAN_DIV=4, SEG_ACT_LOW=1, DIG_ACT_LOW=1)
//  Assert rst mid-run -> seg=7'h7F, dp=1, dig_sel=4'hF, bcd_rdy=1 same cycle.
//  bcd_in=16'h1259 on boundary -> next frame slot0 seg=7'b0010000 (9),
//   slot1 seg=7'b0010010 (5), dig_sel slot0=4'b1110, 4 cycles per slot.
//  bcd_in=16'h0059, blank_lz=1 -> slots 2,3 seg=7'h7F; blank_lz=0 -> 7'b1000000.
//  bcd_in=16'h00A5 -> slot1 seg=7'b0111111 (dash).
//  Two words mid-frame -> first accepted, bcd_rdy=0 until cycle after
//   frame_done, second held then accepted; display shows first, then second.
//  SEG7_DP_BLINK_EN -> dp=1 for frames 0..31, dp=0 on slot 2 for frames 32..63.

Source files
------------

// File: rtl/bcd_seg7_scan_if.sv
// Input handshake bundle for bcd_seg7_scan: one packed BCD word per transfer.
interface bcd_seg7_scan_if #(
    parameter int DIGITS = 4
);
    // A word moves on every rising clk edge where bcd_vld and bcd_rdy are both 1.
    // The master holds bcd_in stable and keeps bcd_vld high until that edge.
    // bcd_rdy never depends on bcd_vld in the same cycle.
    logic [4*DIGITS-1:0] bcd_in;
    logic                bcd_vld;
    logic                bcd_rdy;

    modport master (
        output bcd_in,
        output bcd_vld,
        input  bcd_rdy
    );

    modport slave (
        input  bcd_in,
        input  bcd_vld,
        output bcd_rdy
    );
endinterface

// File: rtl/bcd_seg7_scan.sv
// Time-multiplexed 7-segment driver for a packed BCD word; shadow updates only at frame ends.
// Optional feature macro SEG7_DP_BLINK_EN: blinks dp on digit DP_POS with a 64-frame period.
module bcd_seg7_scan #(
    parameter int DIGITS      = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int SEG_ACT_LOW = 1,
    parameter int DIG_ACT_LOW = 1,
    parameter int DP_POS      = 2
) (
    input  logic              clk,
    input  logic              rst,
    bcd_seg7_scan_if.slave    bcd,
    input  logic              blank_lz,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] dig_sel,
    output logic              frame_done
);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(DIGITS);
    localparam int WORD_W = 4 * DIGITS;

    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0]  IDX_DP   = IDX_W'(DP_POS);
    localparam logic [6:0]        SEG_OFF  = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF   = (SEG_ACT_LOW != 0);
    localparam logic [DIGITS-1:0] DIG_OFF  = (DIG_ACT_LOW != 0) ? '1 : '0;

    logic [PRE_W-1:0]  presc;
    logic [IDX_W-1:0]  idx;
    logic              tc;
    logic              boundary;
    logic              xfer;
    logic [WORD_W-1:0] shadow;
    logic [WORD_W-1:0] pend;
    logic              pend_vld;
    logic [3:0]        digit [DIGITS];
    logic [DIGITS-1:0] lead_zero;
    logic              zero_run;
    logic [3:0]        cur_digit;
    logic [6:0]        seg_next;
    logic [DIGITS-1:0] dig_next;
    logic              dp_on;
    logic              blink_phase;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    assign tc       = (presc == PRE_LAST);
    assign boundary = tc && (idx == IDX_LAST);
    assign xfer     = bcd.bcd_vld && bcd.bcd_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (tc) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A word arriving on the boundary cycle goes straight to the shadow;
    // otherwise it waits in pend and blocks further input until the next boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow   <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
        end else if (boundary) begin
            if (xfer) begin
                shadow <= bcd.bcd_in;
            end else if (pend_vld) begin
                shadow   <= pend;
                pend_vld <= 1'b0;
            end
        end else if (xfer) begin
            pend     <= bcd.bcd_in;
            pend_vld <= 1'b1;
        end
    end

    assign bcd.bcd_rdy = ~pend_vld;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign digit[k] = shadow[4*k +: 4];
    end

    // lead_zero[k] is set when digit k and every digit above it are zero.
    always_comb begin
        zero_run  = 1'b1;
        lead_zero = '0;
        for (int k = DIGITS - 1; k > 0; k--) begin
            zero_run     = zero_run & (digit[k] == 4'd0);
            lead_zero[k] = zero_run;
        end
    end

    assign cur_digit = digit[idx];

    always_comb begin
        seg_next = decode(cur_digit);
        if (blank_lz && lead_zero[idx]) begin
            seg_next = 7'h00;
        end
        if (SEG_ACT_LOW != 0) begin
            seg_next = ~seg_next;
        end
    end

    always_comb begin
        dig_next = DIGITS'(1) << idx;
        if (DIG_ACT_LOW != 0) begin
            dig_next = ~dig_next;
        end
    end

`ifdef SEG7_DP_BLINK_EN
    logic [5:0] frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign blink_phase = frame_cnt[5];
`else
    assign blink_phase = 1'b0;
`endif

    assign dp_on = blink_phase && (idx == IDX_DP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            dig_sel    <= DIG_OFF;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_next;
            dp         <= (SEG_ACT_LOW != 0) ? ~dp_on : dp_on;
            dig_sel    <= dig_next;
            frame_done <= boundary;
        end
    end
endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Bench for bcd_seg7_scan: cycle-indexed reference model checked every cycle, plus literal pins.
module tb_bcd_seg7_scan;
    localparam int D  = 4;
    localparam int SD = 4;
    localparam int F  = D * SD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       blank_lz = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig_sel;
    logic       frame_done;

    bcd_seg7_scan_if #(.DIGITS(D)) bcd_if ();

    bcd_seg7_scan #(
        .DIGITS(D), .SCAN_DIV(SD), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1), .DP_POS(2)
    ) dut (
        .clk(clk), .rst(rst), .bcd(bcd_if), .blank_lz(blank_lz),
        .seg(seg), .dp(dp), .dig_sel(dig_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model: shadow word, accepted-but-not-shown words, history of the previous cycle
    logic [6:0]  seg_tab [16];
    logic [15:0] m_shadow = '0;
    logic [15:0] prev_shadow = '0;
    logic        prev_blank = 1'b0;
    logic [15:0] exp_q [$];
    int          m_k;
    logic [15:0] m_up;
    logic [6:0]  m_seg;
    logic [3:0]  m_dig;
    logic        m_dp;
    logic        m_xfer;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("rst_seg", 32'(seg), 32'h7F);
            check("rst_dp", 32'(dp), 32'd1);
            check("rst_dig_sel", 32'(dig_sel), 32'hF);
            check("rst_frame_done", 32'(frame_done), 32'd0);
            check("rst_bcd_rdy", 32'(bcd_if.bcd_rdy), 32'd1);
            cyc         = 0;
            m_shadow    = '0;
            prev_shadow = '0;
            prev_blank  = 1'b0;
            exp_q.delete();
        end else begin
            if (cyc == 0) begin
                check("idle_seg", 32'(seg), 32'h7F);
                check("idle_dp", 32'(dp), 32'd1);
                check("idle_dig_sel", 32'(dig_sel), 32'hF);
            end else begin
                m_k   = ((cyc - 1) / SD) % D;
                m_up  = prev_shadow >> (4 * m_k);
                m_seg = (prev_blank && m_k > 0 && m_up == 16'd0) ? 7'h7F : ~seg_tab[m_up[3:0]];
                m_dig = ~(4'b0001 << m_k);
                m_dp  = 1'b1;
`ifdef SEG7_DP_BLINK_EN
                if (m_k == 2 && (((cyc - 1) / F) % 64) >= 32) m_dp = 1'b0;
`endif
                check("seg", 32'(seg), 32'(m_seg));
                check("dp", 32'(dp), 32'(m_dp));
                check("dig_sel", 32'(dig_sel), 32'(m_dig));
            end
            check("frame_done", 32'(frame_done), 32'(cyc > 0 && (cyc % F) == 0));
            check("bcd_rdy", 32'(bcd_if.bcd_rdy), 32'(exp_q.size() == 0));
            prev_shadow = m_shadow;
            prev_blank  = blank_lz;
            m_xfer = bcd_if.bcd_vld && (exp_q.size() == 0);
            if ((cyc % F) == F - 1) begin
                if (m_xfer) m_shadow = bcd_if.bcd_in;
                else if (exp_q.size() > 0) m_shadow = exp_q.pop_front();
            end else if (m_xfer) begin
                exp_q.push_back(bcd_if.bcd_in);
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_phase(input int ph);
        int n = 0;
        while ((cyc % F) != ph && n < 2 * F) begin
            tick();
            n++;
        end
        if ((cyc % F) != ph) check("goto_phase_timeout", 32'(cyc % F), 32'(ph));
    endtask

    task automatic send(input logic [15:0] w, output int acc_cyc, output logic acc_fd);
        int n = 0;
        bcd_if.bcd_in  = w;
        bcd_if.bcd_vld = 1'b1;
        while (!bcd_if.bcd_rdy && n < 3 * F) begin
            tick();
            n++;
        end
        acc_cyc = cyc;
        acc_fd  = frame_done;
        if (!bcd_if.bcd_rdy) check("send_timeout", 32'(bcd_if.bcd_rdy), 32'd1);
        tick();
        bcd_if.bcd_vld = 1'b0;
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        case ($urandom_range(0, 3))
            0: w = 16'($urandom);
            1: w = {12'h000, 4'($urandom_range(0, 9))};
            2: w = {8'h00, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            default: begin
                w = '0;
                for (int j = 0; j < 4; j++) w[4*j +: 4] = 4'($urandom_range(0, 9));
            end
        endcase
        return w;
    endfunction

    initial begin
        int   a;
        int   p;
        logic fd;
        logic rdy_seen;
        seg_tab[0] = 7'b0111111; seg_tab[1] = 7'b0000110; seg_tab[2] = 7'b1011011;
        seg_tab[3] = 7'b1001111; seg_tab[4] = 7'b1100110; seg_tab[5] = 7'b1101101;
        seg_tab[6] = 7'b1111101; seg_tab[7] = 7'b0000111; seg_tab[8] = 7'b1111111;
        seg_tab[9] = 7'b1101111;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b1000000;
        bcd_if.bcd_in  = '0;
        bcd_if.bcd_vld = 1'b0;
        rdy_seen = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // word on the boundary cycle bypasses pending
        goto_phase(F - 1);
        send(16'h1259, a, fd);
        check("lit_bypass_rdy", 32'(bcd_if.bcd_rdy), 32'd1);
        tick();
        check("lit_1259_slot0_seg", 32'(seg), 32'(7'b0010000));
        check("lit_1259_slot0_dig", 32'(dig_sel), 32'(4'b1110));
        repeat (3) tick();
        check("lit_1259_slot0_last_dig", 32'(dig_sel), 32'(4'b1110));
        tick();
        check("lit_1259_slot1_seg", 32'(seg), 32'(7'b0010010));
        check("lit_1259_slot1_dig", 32'(dig_sel), 32'(4'b1101));

        // leading-zero blanking on, then off
        blank_lz = 1'b1;
        goto_phase(F - 1);
        send(16'h0059, a, fd);
        repeat (9) tick();
        check("lit_lz_slot2", 32'(seg), 32'h7F);
        repeat (4) tick();
        check("lit_lz_slot3", 32'(seg), 32'h7F);
        blank_lz = 1'b0;
        repeat (12) tick();
        check("lit_nolz_slot2", 32'(seg), 32'(7'b1000000));

        // non-BCD nibble shows a dash
        goto_phase(F - 1);
        send(16'h00A5, a, fd);
        repeat (5) tick();
        check("lit_dash_slot1", 32'(seg), 32'(7'b0111111));

        // two words mid-frame: second waits for the frame end
        goto_phase(5);
        send(16'h0012, a, fd);
        check("lit_pend_rdy_low", 32'(bcd_if.bcd_rdy), 32'd0);
        send(16'h0034, p, fd);
        check("lit_second_phase", 32'(p % F), 32'd0);
        check("lit_second_fd", 32'(fd), 32'd1);
        check("lit_first_shown", 32'(seg), 32'(7'b0100100));
        repeat (16) tick();
        check("lit_second_shown", 32'(seg), 32'(7'b0011001));

        // reset with a word pending: outputs drop at once, pending discarded
        goto_phase(6);
        send(16'h0987, a, fd);
        rst = 1'b1;
        #1;
        check("lit_rst_seg", 32'(seg), 32'h7F);
        check("lit_rst_dp", 32'(dp), 32'd1);
        check("lit_rst_dig", 32'(dig_sel), 32'hF);
        check("lit_rst_rdy", 32'(bcd_if.bcd_rdy), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 0; n < 40 && cyc != 17; n++) tick();
        check("lit_rst_discard", 32'(seg), 32'(7'b1000000));

        // randomized traffic with one random mid-run reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                bcd_if.bcd_vld = 1'b0;
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) tick();
                rst = 1'b0;
            end
            if (!bcd_if.bcd_vld || rdy_seen) begin
                bcd_if.bcd_vld = ($urandom_range(0, 3) == 0);
                bcd_if.bcd_in  = rand_word();
            end
            if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
            rdy_seen = bcd_if.bcd_rdy;
            tick();
        end
        bcd_if.bcd_vld = 1'b0;
        repeat (2 * F) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
